// File: rtl/core_pkg.sv
// core_pkg: shared FSM state encoding and register constants for the core.
package core_pkg;
  typedef enum logic [1:0] {BOOT, RUN, MEM_WAIT, HALT} state_t;
  localparam logic [4:0] REG_X0 = 5'd0;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: boot sequencing, load-use/branch/memory-wait hazard control and
// saturating stall/flush counters for the 5-stage pipeline.
module hazard_ctrl import core_pkg::*; #(
  parameter int START_DELAY = 4,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [4:0]       ifid_rs1_i,
  input  logic [4:0]       ifid_rs2_i,
  input  logic [4:0]       idex_rd_i,
  input  logic             idex_memread_i,
  input  logic             branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  output logic             start_o,
  output logic             pc_write_o,
  output logic             ifid_stall_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             freeze_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);
  localparam int BW = $clog2(START_DELAY + 1);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);

  state_t          state;
  logic            armed;
  logic [BW-1:0]   boot_cnt;
  logic [WW-1:0]   wait_cnt;
  logic            run, mem_wait, load_use, branch, stall_inc;

  assign run       = state == RUN;
  assign mem_wait  = mem_req_i && !mem_ready_i;
  assign load_use  = idex_memread_i && idex_rd_i != REG_X0 &&
                     (idex_rd_i == ifid_rs1_i || idex_rd_i == ifid_rs2_i);
  // Memory wait outranks load-use, which in turn masks a same-cycle branch.
  assign branch    = run && !mem_wait && !load_use && branch_taken_i;
  assign stall_inc = state == MEM_WAIT || (run && (mem_wait || load_use));

  always_comb begin
    freeze_o      = state == MEM_WAIT || state == HALT || (run && mem_wait);
    pc_write_o    = run && !mem_wait && !load_use;
    ifid_stall_o  = state == MEM_WAIT || (run && (mem_wait || load_use));
    ifid_flush_o  = state == BOOT || branch;
    idex_bubble_o = run && !mem_wait && load_use;
  end

  // armed delays counting by one edge so start_o rises START_DELAY cycles after
  // the first clock edge that sees reset released.
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state     <= BOOT;
      armed     <= 1'b0;
      boot_cnt  <= '0;
      wait_cnt  <= '0;
      start_o   <= 1'b0;
      mem_err_o <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          armed <= 1'b1;
          if (armed) begin
            if (boot_cnt == BW'(START_DELAY - 1)) begin
              state   <= RUN;
              start_o <= 1'b1;
            end else boot_cnt <= boot_cnt + 1'b1;
          end
        end
        RUN: if (mem_wait) begin
          state    <= MEM_WAIT;
          wait_cnt <= '0;
        end
        MEM_WAIT: begin
          if (mem_ready_i) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WW'(MEM_TIMEOUT - 1)) begin
            state     <= HALT;
            mem_err_o <= 1'b1;
            start_o   <= 1'b0;
          end else wait_cnt <= wait_cnt + 1'b1;
        end
        HALT: start_o <= 1'b0;
      endcase
    end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk_i), .rst_n(rst_n_i), .inc(stall_inc), .count(stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk_i), .rst_n(rst_n_i), .inc(branch), .count(flush_cnt_o)
  );
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed tests of boot, load-use, x0, memory wait, timeout
// and counter saturation with START_DELAY=4, MEM_TIMEOUT=8, CNT_W=4.
module tb_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic       memread = 1'b0, br = 1'b0, req = 1'b0, rdy = 1'b0;
  logic       start, pcw, stall, flush, bubble, freeze, err;
  logic [3:0] stall_cnt, flush_cnt;
  int         tests = 0, fails = 0;

  hazard_ctrl #(.START_DELAY(4), .MEM_TIMEOUT(8), .CNT_W(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .ifid_rs1_i(rs1), .ifid_rs2_i(rs2),
    .idex_rd_i(rd), .idex_memread_i(memread), .branch_taken_i(br),
    .mem_req_i(req), .mem_ready_i(rdy), .start_o(start), .pc_write_o(pcw),
    .ifid_stall_o(stall), .ifid_flush_o(flush), .idex_bubble_o(bubble),
    .freeze_o(freeze), .mem_err_o(err), .stall_cnt_o(stall_cnt),
    .flush_cnt_o(flush_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    rs1 = '0; rs2 = '0; rd = '0; memread = 1'b0; br = 1'b0; req = 1'b0; rdy = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic boot();
    clear_inputs();
    @(posedge clk); #2; rst_n = 1'b0; #1; rst_n = 1'b1;
    repeat (5) tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    @(posedge clk); #3; rst_n = 1'b0; #1;
    tests++; if (start !== 1'b0) begin fails++; $display("FAIL rst_start: got %b expected 0", start); end
    tests++; if (flush !== 1'b1) begin fails++; $display("FAIL rst_flush: got %b expected 1", flush); end
    tests++; if ({pcw, stall, bubble, freeze, err} !== 5'b0) begin fails++; $display("FAIL rst_ctrl: got %b expected 00000", {pcw, stall, bubble, freeze, err}); end
    tests++; if ({stall_cnt, flush_cnt} !== 8'h00) begin fails++; $display("FAIL rst_cnt: got %h expected 00", {stall_cnt, flush_cnt}); end
    @(posedge clk); #1; rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      tests++; if (start !== 1'b0) begin fails++; $display("FAIL boot_start_low edge %0d: got %b expected 0", i, start); end
      tests++; if (flush !== 1'b1) begin fails++; $display("FAIL boot_flush edge %0d: got %b expected 1", i, flush); end
    end
    tick();
    tests++; if (start !== 1'b1) begin fails++; $display("FAIL boot_start_high: got %b expected 1", start); end
    tests++; if ({pcw, flush, stall} !== 3'b100) begin fails++; $display("FAIL run_idle: got %b expected 100", {pcw, flush, stall}); end
    tests++; if (flush_cnt !== 4'd0) begin fails++; $display("FAIL boot_flush_uncounted: got %0d expected 0", flush_cnt); end
  endtask

  task automatic test_load_use();
    boot();
    memread = 1'b1; rd = 5'd5; rs1 = 5'd3; rs2 = 5'd5; br = 1'b1; #1;
    tests++; if ({stall, bubble, pcw, flush, freeze} !== 5'b11000) begin fails++; $display("FAIL load_use_ctrl: got %b expected 11000", {stall, bubble, pcw, flush, freeze}); end
    tick();
    tests++; if (stall_cnt !== 4'd1) begin fails++; $display("FAIL load_use_stall_cnt: got %0d expected 1", stall_cnt); end
    tests++; if (flush_cnt !== 4'd0) begin fails++; $display("FAIL load_use_flush_cnt: got %0d expected 0", flush_cnt); end
    rs2 = 5'd0; rs1 = 5'd5; br = 1'b0; #1;
    tests++; if ({stall, bubble} !== 2'b11) begin fails++; $display("FAIL load_use_rs1: got %b expected 11", {stall, bubble}); end
    clear_inputs(); #1;
    tests++; if ({pcw, stall, bubble} !== 3'b100) begin fails++; $display("FAIL load_use_release: got %b expected 100", {pcw, stall, bubble}); end
  endtask

  task automatic test_x0();
    boot();
    memread = 1'b1; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; #1;
    tests++; if ({stall, bubble, pcw} !== 3'b001) begin fails++; $display("FAIL x0_no_stall: got %b expected 001", {stall, bubble, pcw}); end
    rd = 5'd7; rs1 = 5'd3; rs2 = 5'd4; #1;
    tests++; if ({stall, bubble, pcw} !== 3'b001) begin fails++; $display("FAIL no_match: got %b expected 001", {stall, bubble, pcw}); end
    memread = 1'b0; rs1 = 5'd7; #1;
    tests++; if ({stall, bubble, pcw} !== 3'b001) begin fails++; $display("FAIL no_load: got %b expected 001", {stall, bubble, pcw}); end
    tick();
    tests++; if (stall_cnt !== 4'd0) begin fails++; $display("FAIL x0_stall_cnt: got %0d expected 0", stall_cnt); end
  endtask

  task automatic test_mem_wait();
    int frz = 0;
    boot();
    req = 1'b1; rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1; if (freeze === 1'b1 && pcw === 1'b0 && stall === 1'b1) frz++;
      tick();
    end
    rdy = 1'b1; #1;
    if (freeze === 1'b1 && pcw === 1'b0) frz++;
    tick();
    req = 1'b0; rdy = 1'b0; #1;
    tests++; if (frz !== 4) begin fails++; $display("FAIL mem_freeze_cycles: got %0d expected 4", frz); end
    tests++; if ({freeze, pcw} !== 2'b01) begin fails++; $display("FAIL mem_back_to_run: got %b expected 01", {freeze, pcw}); end
    tests++; if (stall_cnt !== 4'd4) begin fails++; $display("FAIL mem_stall_cnt: got %0d expected 4", stall_cnt); end
    req = 1'b1; rdy = 1'b1; #1;
    tests++; if ({freeze, pcw} !== 2'b01) begin fails++; $display("FAIL mem_same_cycle_ready: got %b expected 01", {freeze, pcw}); end
    tick(); #1;
    tests++; if ({freeze, stall_cnt} !== 5'b0_0100) begin fails++; $display("FAIL mem_no_state_change: got %b expected 00100", {freeze, stall_cnt}); end
    req = 1'b1; rdy = 1'b0; memread = 1'b1; rd = 5'd2; rs1 = 5'd2; br = 1'b1; #1;
    tests++; if ({freeze, bubble, flush, pcw} !== 4'b1000) begin fails++; $display("FAIL mem_priority: got %b expected 1000", {freeze, bubble, flush, pcw}); end
    clear_inputs();
  endtask

  task automatic test_timeout();
    int n = 0;
    boot();
    req = 1'b1; rdy = 1'b0;
    while (err !== 1'b1 && n < 30) begin
      tick(); n++;
    end
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL timeout_err: got %b expected 1 within 30 cycles", err); end
    tests++; if (n < 8) begin fails++; $display("FAIL timeout_early: got %0d cycles expected at least 8", n); end
    tests++; if ({start, freeze, pcw} !== 3'b010) begin fails++; $display("FAIL halt_ctrl: got %b expected 010", {start, freeze, pcw}); end
    req = 1'b0; repeat (3) tick();
    tests++; if ({start, err, freeze} !== 3'b011) begin fails++; $display("FAIL halt_sticky: got %b expected 011", {start, err, freeze}); end
    #2; rst_n = 1'b0; #1;
    tests++; if ({err, flush, freeze} !== 3'b010) begin fails++; $display("FAIL reset_clears_err: got %b expected 010", {err, flush, freeze}); end
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (5) tick();
    tests++; if ({start, pcw} !== 2'b11) begin fails++; $display("FAIL reboot: got %b expected 11", {start, pcw}); end
  endtask

  task automatic test_saturation();
    boot();
    br = 1'b1; #1;
    tests++; if ({flush, pcw, stall} !== 3'b110) begin fails++; $display("FAIL branch_ctrl: got %b expected 110", {flush, pcw, stall}); end
    repeat (10) tick();
    tests++; if (flush_cnt !== 4'd10) begin fails++; $display("FAIL flush_cnt_10: got %0d expected 10", flush_cnt); end
    repeat (10) tick();
    tests++; if (flush_cnt !== 4'd15) begin fails++; $display("FAIL flush_cnt_sat: got %0d expected 15", flush_cnt); end
    tests++; if (stall_cnt !== 4'd0) begin fails++; $display("FAIL sat_stall_cnt: got %0d expected 0", stall_cnt); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_x0();
    test_mem_wait();
    test_timeout();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
